// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between NREQ requesters and the shared-ALU sequencer.
// master = requester side, slave = sequencer side.
interface alu_share_ctrl_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_y;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_overflow
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one combinational 4-bit ALU between NREQ requesters.
// One transaction in flight at a time: IDLE (grant) -> EXEC (ALU settles) -> RESP (hand back).
module alu_share_ctrl #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_ctrl_if.slave    bus,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_op,
  input  logic [3:0]         alu_y,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  output logic               busy,
  output logic [7:0]         done_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_grant_q;
  logic [3:0]      alu_a_q, alu_b_q;
  logic [2:0]      alu_op_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [3:0]      rsp_y_q;
  logic            rsp_zero_q, rsp_carry_q, rsp_overflow_q;
  logic [7:0]      done_cnt_q;

  logic            grant_valid;
  int unsigned     grant_idx;
  int unsigned     idx;
  logic [NREQ-1:0] req_ready;
  logic            hs;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(last_grant_q) + k + 1) % NREQ;
      if (!grant_valid && bus.req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on state and req_valid; rsp_ready never reaches req_ready.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == StIdle) && grant_valid && (grant_idx == i);
    end
    hs   = (state_q == StIdle) && grant_valid;
    busy = (state_q != StIdle);
  end

  // last_grant_q doubles as the pending id: both hold the most recently accepted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q   <= IDW'(NREQ - 1);
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_y_q        <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      done_cnt_q     <= '0;
    end else begin
      if (hs) begin
        alu_a_q      <= bus.req_a[4*grant_idx +: 4];
        alu_b_q      <= bus.req_b[4*grant_idx +: 4];
        alu_op_q     <= bus.req_op[3*grant_idx +: 3];
        last_grant_q <= IDW'(grant_idx);
      end
      if (state_q == StExec) begin
        rsp_y_q        <= alu_y;
        rsp_zero_q     <= alu_zero;
        rsp_carry_q    <= alu_carry;
        rsp_overflow_q <= alu_overflow;
        rsp_id_q       <= last_grant_q;
        rsp_valid_q    <= 1'b1;
      end
      if ((state_q == StResp) && rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        done_cnt_q  <= done_cnt_q + 8'd1;
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
  assign done_cnt         = done_cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed + randomized bench for alu_share_ctrl; the bench also plays the shared ALU.
module tb_alu_share_ctrl;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_op;
  logic       alu_zero, alu_carry, alu_overflow;
  logic       busy;
  logic [7:0] done_cnt;

  int checks = 0;
  int errors = 0;
  int last_model = NREQ - 1;
  int done_model = 0;

  alu_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_y        (alu_y),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .done_cnt     (done_cnt)
  );

  always #5 clk = ~clk;

  // Reference ALU from plain integer arithmetic; returns {zero, carry, overflow, y}.
  function automatic logic [6:0] alu_ref(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [3:0] y;
    ua = a; ub = b;
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    r = 0; s = 0; c = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 15);   s = sa + sb; end
      3'd1: begin r = ua - ub; c = (ua < ub);  s = sa - sb; end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ~ua;
      3'd6: begin r = ua + 1;  c = (ua == 15); s = sa + 1;  end
      default: begin r = ua - 1; c = (ua == 0); s = sa - 1; end
    endcase
    v = (s > 7) || (s < -8);
    y = r[3:0];
    return {(y == 4'd0), c, v, y};
  endfunction

  always_comb begin
    logic [6:0] res;
    res = alu_ref(alu_a, alu_b, alu_op);
    {alu_zero, alu_carry, alu_overflow, alu_y} = res;
  end

  function automatic int exp_grant(logic [NREQ-1:0] mask, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    bus.req_a[4*i +: 4]  = a;
    bus.req_b[4*i +: 4]  = b;
    bus.req_op[3*i +: 3] = op;
  endtask

  function automatic logic [6:0] rsp_vec();
    return {bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_y};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
    last_model = NREQ - 1;
    done_model = 0;
  endtask

  // One full transaction: arbitration, EXEC, RESP with `hold` cycles of back-pressure.
  task automatic transact(input logic [NREQ-1:0] mask, input bit keep, input int hold,
                          output int g);
    int cyc;
    logic [3:0] ea, eb;
    logic [2:0] eo;
    logic [6:0] er;
    bus.req_valid = bus.req_valid | mask;
    bus.rsp_ready = (hold == 0);
    #1;
    cyc = 0;
    while (bus.req_ready == '0 && cyc < 20) begin
      nxt();
      cyc++;
    end
    chk("grant_seen", 32'(bus.req_ready != '0), 1);
    if (bus.req_ready == '0) begin
      g = -1;
      bus.req_valid = '0;
      return;
    end
    chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
    g = 0;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
    chk("grant_order", g, exp_grant(bus.req_valid, last_model));
    ea = bus.req_a[4*g +: 4];
    eb = bus.req_b[4*g +: 4];
    eo = bus.req_op[3*g +: 3];
    er = alu_ref(ea, eb, eo);
    nxt();
    last_model = g;
    if (!keep) bus.req_valid[g] = 1'b0;
    #1;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_ready", 32'(bus.req_ready), 0);
    chk("alu_operands", {21'd0, alu_op, alu_a, alu_b}, {21'd0, eo, ea, eb});
    nxt();
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_id", 32'(bus.rsp_id), g);
    chk("rsp_result", 32'(rsp_vec()), 32'(er));
    for (int h = 0; h < hold; h++) begin
      chk("hold_stable", {23'd0, bus.rsp_valid, rsp_vec()}, {23'd0, 1'b1, er});
      chk("hold_ready_busy", {29'd0, bus.req_ready, busy}, 32'd1);
      if (h == hold - 1) bus.rsp_ready = 1'b1;
      nxt();
    end
    if (hold == 0) nxt();
    done_model = (done_model + 1) % 256;
    chk("rsp_dropped", 32'(bus.rsp_valid), 0);
    chk("done_cnt", 32'(done_cnt), done_model);
    chk("idle_busy", 32'(busy), 0);
    chk("rsp_retained", 32'(rsp_vec()), 32'(er));
  endtask

  initial begin
    int g;
    bit  seen_rsp;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    nxt();
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_fields", {23'd0, bus.rsp_id, rsp_vec()}, 0);
    chk("rst_alu", {21'd0, alu_op, alu_a, alu_b}, 0);
    chk("rst_done", 32'(done_cnt), 0);

    // Requester 0 ADD 7+9
    set_req(0, 4'd7, 4'd9, 3'b000);
    transact(2'b01, 1'b0, 0, g);
    chk("t1_rsp", {24'd0, bus.rsp_id, rsp_vec()}, {24'd0, 2'd0, 7'b1100000});
    chk("t1_done", 32'(done_cnt), 1);

    // Requester 1 SUB 8-1
    set_req(1, 4'd8, 4'd1, 3'b001);
    transact(2'b10, 1'b0, 0, g);
    chk("t2_rsp", {24'd0, bus.rsp_id, rsp_vec()}, {24'd0, 2'd1, 7'b0010111});

    // Both continuously valid from reset: strict alternation
    do_reset();
    set_req(0, 4'd3, 4'd5, 3'b010);
    set_req(1, 4'd12, 4'd6, 3'b100);
    for (int t = 0; t < 4; t++) begin
      transact(2'b11, 1'b1, 0, g);
      chk("alternate", g, t % 2);
    end
    bus.req_valid = '0;
    nxt();

    // Response back-pressure for 5 cycles
    set_req(0, 4'd10, 4'd13, 3'b011);
    transact(2'b01, 1'b0, 5, g);

    // Randomized traffic; operands change only while a requester is idle
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i])
          set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
      end
      transact(2'($urandom_range(1, 3)), 1'b0, int'($urandom_range(0, 3)), g);
    end
    bus.req_valid = '0;
    nxt();

    // Reset during EXEC aborts the transaction
    chk("pre_abort_done_nz", 32'(done_cnt != 8'd0), 1);
    set_req(1, 4'd9, 4'd4, 3'b000);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd2);
    nxt();
    chk("abort_in_exec", 32'(busy), 1);
    rst = 1'b1;
    bus.req_valid = '0;
    nxt();
    rst = 1'b0;
    last_model = NREQ - 1;
    done_model = 0;
    chk("abort_state", {29'd0, busy, bus.rsp_valid, 1'b0}, 0);
    chk("abort_done", 32'(done_cnt), 0);
    chk("abort_alu", {21'd0, alu_op, alu_a, alu_b}, 0);
    seen_rsp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid) seen_rsp = 1'b1;
      nxt();
    end
    chk("abort_no_rsp", 32'(seen_rsp), 0);

    // 256 back-to-back INC on 15: done_cnt wraps to 0
    do_reset();
    set_req(0, 4'd15, 4'd0, 3'b110);
    for (int t = 0; t < 256; t++) begin
      transact(2'b01, 1'b1, 0, g);
      chk("inc_rsp", {25'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_overflow, bus.rsp_y},
          {25'd0, 1'b1, 1'b1, 1'b0, 4'd0});
    end
    bus.req_valid = '0;
    chk("wrap_done", 32'(done_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
